// File: rtl/axil_pwm_pkg.sv
// Shared definitions for the AXI4-Lite PWM register block.
//   - register byte offsets within the 16-byte window
//   - CTRL bit positions
//   - AXI response codes
//   - reset values of PERIOD and DUTY
//   - write-channel FSM state type and a byte-lane merge helper
package axil_pwm_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_PERIOD = 4'h4;
  localparam logic [3:0] ADDR_DUTY   = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] PERIOD_RST = 32'h0000_FFFF;
  localparam logic [31:0] DUTY_RST   = 32'h0000_8000;

  // COLLECT: waiting for AW and/or W; UPDATE: both held, register file
  // written on this edge; RESP: B channel valid until bready.
  typedef enum logic [1:0] {
    WR_COLLECT = 2'd0,
    WR_UPDATE  = 2'd1,
    WR_RESP    = 2'd2
  } wr_state_e;

  // Replace only the bits selected by mask (one 8-bit run per strobe).
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/axil_pwm_core.sv
// Single-channel PWM generator.
//   s00_axi_aclk   : clock (rising edge)
//   s00_axi_areset : asynchronous active-high reset
//   en, inv        : CTRL.EN / CTRL.INV
//   period, duty   : programmed PERIOD / DUTY register values
//   cnt            : current counter value (STATUS readback)
//   pwm_out        : registered output, one cycle behind cnt
// Build option AXIL_PWM_SHADOW_EN: period/duty are treated as shadow values
// and only copied into the active compare values on the wrap cycle or while
// disabled. Without it the programmed values are used directly.
module axil_pwm_core
  import axil_pwm_pkg::*;
(
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_areset,
  input  logic        en,
  input  logic        inv,
  input  logic [31:0] period,
  input  logic [31:0] duty,
  output logic [31:0] cnt,
  output logic        pwm_out
);

  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] p_act, d_act;
  logic        wrap;
  logic        raw;
  logic        pwm_reg;

`ifdef AXIL_PWM_SHADOW_EN
  logic [31:0] p_reg, d_reg;

  // Loading while disabled means the first enabled period already uses the
  // latest programmed values.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      p_reg <= PERIOD_RST;
      d_reg <= DUTY_RST;
    end else if (!en || wrap) begin
      p_reg <= period;
      d_reg <= duty;
    end
  end

  assign p_act = p_reg;
  assign d_act = d_reg;
`else
  assign p_act = period;
  assign d_act = duty;
`endif

  // >= rather than == so a PERIOD lowered below the running count wraps
  // immediately instead of running on to 2^32.
  assign wrap = (cnt_reg >= p_act);
  assign raw  = en & (cnt_reg < d_act);

  always_comb begin
    cnt_next = cnt_reg + 32'd1;
    if (!en || wrap) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      cnt_reg <= '0;
      pwm_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      pwm_reg <= raw ^ inv;
    end
  end

  assign cnt     = cnt_reg;
  assign pwm_out = pwm_reg;

endmodule

// File: rtl/axil_pwm_regs.sv
// AXI4-Lite responder with four 32-bit registers driving axil_pwm_core.
//   0x0 CTRL (EN bit0, INV bit1), 0x4 PERIOD, 0x8 DUTY, 0xC STATUS (RO, cnt)
// Ports: s00_axi_* AXI4-Lite slave (aclk, areset async active-high,
// AW/W/B/AR/R channels), pwm_out registered PWM output.
// AW and W are captured independently into holding registers; the register
// file is written the edge after both are held, then B is presented.
// Reads load RDATA/RRESP on the AR handshake edge. Accesses with any address
// bit at or above bit 4 set get SLVERR and have no effect.
// Build option AXIL_PWM_SHADOW_EN: PERIOD/DUTY become shadow registers that
// the core picks up at the end of a period (see axil_pwm_core).
module axil_pwm_regs
  import axil_pwm_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 14
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              pwm_out
);

  localparam int AW = C_S00_AXI_ADDR_WIDTH;

  // Held low through reset and for the first cycle after so no handshake
  // can complete while the block is still coming out of reset.
  logic ready_en_reg;

  logic          aw_held_reg, w_held_reg;
  logic [AW-1:0] awaddr_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    wstrb_reg;
  logic [31:0]   wmask;

  wr_state_e wr_state_reg, wr_state_next;
  logic      wr_update, bvalid;
  logic [1:0] bresp_reg;

  logic [1:0]  ctrl_reg;
  logic [31:0] period_reg, duty_reg;
  logic [31:0] cnt;

  logic        rvalid_reg;
  logic [31:0] rdata_reg, rd_data;
  logic [1:0]  rresp_reg;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_in_range, rd_in_range;
  logic [3:0] wr_offset, rd_offset;
  logic unused_sigs;

  assign s00_axi_awready = ready_en_reg & ~aw_held_reg & ~bvalid;
  assign s00_axi_wready  = ready_en_reg & ~w_held_reg & ~bvalid;
  assign s00_axi_arready = ready_en_reg & ~rvalid_reg;

  assign aw_hs = s00_axi_awvalid & s00_axi_awready;
  assign w_hs  = s00_axi_wvalid & s00_axi_wready;
  assign b_hs  = bvalid & s00_axi_bready;
  assign ar_hs = s00_axi_arvalid & s00_axi_arready;
  assign r_hs  = rvalid_reg & s00_axi_rready;

  assign unused_sigs = ^{s00_axi_awprot, s00_axi_arprot,
                         awaddr_reg[1:0], s00_axi_araddr[1:0]};

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

  // Holding registers: either channel may arrive first; both stay held
  // until the B handshake (ready is low meanwhile, so no overlap).
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      if (b_hs) begin
        aw_held_reg <= 1'b0;
      end else if (aw_hs) begin
        aw_held_reg <= 1'b1;
        awaddr_reg  <= s00_axi_awaddr;
      end
      if (b_hs) begin
        w_held_reg <= 1'b0;
      end else if (w_hs) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= s00_axi_wdata;
        wstrb_reg  <= s00_axi_wstrb;
      end
    end
  end

  // Write FSM: state register / next state / outputs.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wr_state_reg <= WR_COLLECT;
    end else begin
      wr_state_reg <= wr_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      WR_COLLECT: begin
        if ((aw_held_reg | aw_hs) & (w_held_reg | w_hs)) begin
          wr_state_next = WR_UPDATE;
        end
      end
      WR_UPDATE: wr_state_next = WR_RESP;
      WR_RESP: begin
        if (s00_axi_bready) begin
          wr_state_next = WR_COLLECT;
        end
      end
      default: wr_state_next = WR_COLLECT;
    endcase
  end

  always_comb begin
    wr_update = 1'b0;
    bvalid    = 1'b0;
    case (wr_state_reg)
      WR_UPDATE: wr_update = 1'b1;
      WR_RESP:   bvalid    = 1'b1;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wmask[8*gi +: 8] = {8{wstrb_reg[gi]}};
  end

  assign wr_in_range = (awaddr_reg[AW-1:4] == '0);
  assign wr_offset   = {awaddr_reg[3:2], 2'b00};

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      bresp_reg  <= RESP_OKAY;
      ctrl_reg   <= '0;
      period_reg <= PERIOD_RST;
      duty_reg   <= DUTY_RST;
    end else if (wr_update) begin
      bresp_reg <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_range) begin
        case (wr_offset)
          ADDR_CTRL:   ctrl_reg   <= (ctrl_reg & ~wmask[1:0]) | (wdata_reg[1:0] & wmask[1:0]);
          ADDR_PERIOD: period_reg <= merge_bytes(period_reg, wdata_reg, wmask);
          ADDR_DUTY:   duty_reg   <= merge_bytes(duty_reg, wdata_reg, wmask);
          default: ;  // STATUS is read-only
        endcase
      end
    end
  end

  assign s00_axi_bvalid = bvalid;
  assign s00_axi_bresp  = bresp_reg;

  // Read path. The mux sees pre-update register values, so a read that
  // lands on the same edge as a write update returns the old contents.
  assign rd_in_range = (s00_axi_araddr[AW-1:4] == '0);
  assign rd_offset   = {s00_axi_araddr[3:2], 2'b00};

  always_comb begin
    rd_data = '0;
    case (rd_offset)
      ADDR_CTRL:   rd_data = {30'b0, ctrl_reg};
      ADDR_PERIOD: rd_data = period_reg;
      ADDR_DUTY:   rd_data = duty_reg;
      ADDR_STATUS: rd_data = cnt;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_in_range ? rd_data : 32'h0;
      rresp_reg  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign s00_axi_rvalid = rvalid_reg;
  assign s00_axi_rdata  = rdata_reg;
  assign s00_axi_rresp  = rresp_reg;

  axil_pwm_core u_core (
    .s00_axi_aclk   (s00_axi_aclk),
    .s00_axi_areset (s00_axi_areset),
    .en             (ctrl_reg[CTRL_EN_BIT]),
    .inv            (ctrl_reg[CTRL_INV_BIT]),
    .period         (period_reg),
    .duty           (duty_reg),
    .cnt            (cnt),
    .pwm_out        (pwm_out)
  );

endmodule

// File: tb/tb_axil_pwm_regs.sv
// Bench for axil_pwm_regs: table of AXI transactions with expected responses
// pushed into B/R scoreboards, plus hand-written PWM waveform, back-pressure,
// same-edge read/write, period-update and reset-abort sequences.
module tb_axil_pwm_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [13:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        pwm_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic [1:0] bq[$];
  rd_exp_t    rq[$];

  typedef struct packed {
    logic              wr;
    logic [13:0]       addr;
    logic [31:0]       data;
    logic [3:0]        strb;
    logic signed [7:0] lead;  // >0: W leads AW by n cycles, <0: AW leads
    logic [31:0]       exp_data;
    logic [1:0]        exp_resp;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axil_pwm_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (3'b000),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (3'b000),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .pwm_out         (pwm_out)
  );

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: pop an expectation on every B / R handshake.
  always @(negedge clk) begin
    logic [1:0] eb;
    rd_exp_t    er;
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) begin
        check_eq("b_unexpected", 64'(bresp), 64'hDEAD);
      end else begin
        eb = bq.pop_front();
        $display("t=%0t B resp=%0d (want %0d)", $time, bresp, eb);
        check_eq("bresp", 64'(bresp), 64'(eb));
      end
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        check_eq("r_unexpected", 64'(rdata), 64'hDEAD);
      end else begin
        er = rq.pop_front();
        $display("t=%0t R data=0x%08h resp=%0d (want 0x%08h/%0d)", $time, rdata, rresp, er.data, er.resp);
        check_eq("rdata", 64'(rdata), 64'(er.data));
        check_eq("rresp", 64'(rresp), 64'(er.resp));
      end
    end
  end

  // Called at posedge+1. hold = cycles bready stays low once bvalid is up.
  task automatic axi_write(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int hold, input logic [1:0] exp);
    int  aw_start, w_start, n;
    bit  aw_done, w_done, aw_hs, w_hs;
    logic [1:0] held;
    bq.push_back(exp);
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      if (!aw_done && n >= aw_start) begin awaddr = addr; awvalid = 1'b1; end
      if (!w_done && n >= w_start) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
      n++;
    end
    check_eq("aw_w_accept", 64'(aw_done && w_done), 64'd1);
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("bvalid_rise", 64'(bvalid), 64'd1);
    held = bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("b_hold", {bvalid, bresp, awready, wready}, {1'b1, held, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [13:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    int n;
    bit done, hs;
    logic [33:0] held;
    rq.push_back({exp_data, exp_resp});
    araddr = addr; arvalid = 1'b1; done = 0; n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      if (hs) begin done = 1; arvalid = 1'b0; end
      n++;
    end
    check_eq("ar_accept", 64'(done), 64'd1);
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("rvalid_rise", 64'(rvalid), 64'd1);
    held = {rdata, rresp};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("r_hold", {rvalid, rdata, rresp, arready}, {1'b1, held, 1'b0});
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Wait for the start of an active phase, then check two full periods.
  task automatic pwm_pattern(input string name, input int high_len, input int period, input bit inv);
    bit prev, cur, found;
    found = 0;
    @(negedge clk); prev = pwm_out;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk); cur = pwm_out;
      if (prev == inv && cur == !inv) found = 1;
      prev = cur;
    end
    check_eq({name, "_edge"}, 64'(found), 64'd1);
    for (int i = 1; i < 2 * period; i++) begin
      @(negedge clk);
      check_eq(name, 64'(pwm_out), 64'(((i % period) < high_len) ? !inv : inv));
    end
    @(posedge clk); #1;
  endtask

  task automatic pwm_const(input string name, input bit level);
    repeat (25) @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check_eq(name, 64'(pwm_out), 64'(level));
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rise(input string name, output int at);
    bit prev, cur, found;
    found = 0; at = 0;
    @(negedge clk); prev = pwm_out;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk); cur = pwm_out;
      if (!prev && cur) begin found = 1; at = cyc; end
      prev = cur;
    end
    check_eq(name, 64'(found), 64'd1);
  endtask

  initial begin
    int r0, r1, r2;

    vecs[0]  = '{1'b1, 14'h0004, 32'h0000_0009, 4'hF,  2, 32'h0,         OKAY};
    vecs[1]  = '{1'b0, 14'h0004, 32'h0,         4'h0,  0, 32'h0000_0009, OKAY};
    vecs[2]  = '{1'b1, 14'h0008, 32'h1234_5678, 4'hF, -2, 32'h0,         OKAY};
    vecs[3]  = '{1'b1, 14'h0008, 32'h0000_00AA, 4'h1,  0, 32'h0,         OKAY};
    vecs[4]  = '{1'b0, 14'h0008, 32'h0,         4'h0,  0, 32'h1234_56AA, OKAY};
    vecs[5]  = '{1'b0, 14'h0000, 32'h0,         4'h0,  0, 32'h0,         OKAY};
    vecs[6]  = '{1'b0, 14'h000C, 32'h0,         4'h0,  0, 32'h0,         OKAY};
    vecs[7]  = '{1'b0, 14'h0010, 32'h0,         4'h0,  0, 32'h0,         SLVERR};
    vecs[8]  = '{1'b1, 14'h0010, 32'hFFFF_FFFF, 4'hF,  0, 32'h0,         SLVERR};
    vecs[9]  = '{1'b0, 14'h0000, 32'h0,         4'h0,  0, 32'h0,         OKAY};
    vecs[10] = '{1'b0, 14'h0004, 32'h0,         4'h0,  0, 32'h0000_0009, OKAY};
    vecs[11] = '{1'b0, 14'h0008, 32'h0,         4'h0,  0, 32'h1234_56AA, OKAY};
    vecs[12] = '{1'b1, 14'h0000, 32'hFFFF_FFFF, 4'hE,  1, 32'h0,         OKAY};
    vecs[13] = '{1'b0, 14'h0000, 32'h0,         4'h0,  0, 32'h0,         OKAY};
    vecs[14] = '{1'b1, 14'h000C, 32'h0000_1234, 4'hF,  0, 32'h0,         OKAY};
    vecs[15] = '{1'b0, 14'h000C, 32'h0,         4'h0,  0, 32'h0,         OKAY};
    vecs[16] = '{1'b1, 14'h0008, 32'h0000_FF00, 4'h2, -1, 32'h0,         OKAY};
    vecs[17] = '{1'b0, 14'h0008, 32'h0,         4'h0,  0, 32'h1234_FFAA, OKAY};
    vecs[18] = '{1'b0, 14'h2000, 32'h0,         4'h0,  0, 32'h0,         SLVERR};
    vecs[19] = '{1'b1, 14'h0000, 32'hFFFF_FFFE, 4'h1,  0, 32'h0,         OKAY};
    vecs[20] = '{1'b0, 14'h0000, 32'h0,         4'h0,  0, 32'h0000_0002, OKAY};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", {awready, wready, arready}, 3'b000);
    check_eq("reset_valid", {bvalid, rvalid}, 2'b00);
    check_eq("reset_data", {rdata, rresp, bresp, pwm_out}, 37'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_after_reset", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr)
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, int'(vecs[i].lead), 0, vecs[i].exp_resp);
      else
        axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, 0);
    end

    // CTRL = INV only: output sits high while disabled
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("inv_disabled", 64'(pwm_out), 64'd1);
    @(posedge clk); #1;
    axi_write(14'h0000, 32'h0, 4'hF, 0, 0, OKAY);

    // Read lands on the same edge as the write update: old value returned
    fork
      axi_write(14'h0004, 32'h0000_0055, 4'hF, 0, 0, OKAY);
      begin
        @(posedge clk); #1;
        axi_read(14'h0004, 32'h0000_0009, OKAY, 0);
      end
    join
    axi_read(14'h0004, 32'h0000_0055, OKAY, 0);

    // Back-pressure on B and R
    axi_write(14'h0008, 32'h0000_0003, 4'hF, 0, 5, OKAY);
    axi_read(14'h0008, 32'h0000_0003, OKAY, 5);
    axi_read(14'h0008, 32'h0000_0003, OKAY, 0);

    // PWM waveforms
    axi_write(14'h0004, 32'd9, 4'hF, 0, 0, OKAY);
    axi_write(14'h0000, 32'h1, 4'hF, 0, 0, OKAY);
    pwm_pattern("pwm_d3_p9", 3, 10, 1'b0);
    axi_write(14'h0000, 32'h3, 4'hF, 0, 0, OKAY);
    pwm_pattern("pwm_inv", 3, 10, 1'b1);
    axi_write(14'h0000, 32'h1, 4'hF, 0, 0, OKAY);
    axi_write(14'h0008, 32'd0, 4'hF, 0, 0, OKAY);
    pwm_const("pwm_duty0", 1'b0);
    axi_write(14'h0008, 32'd20, 4'hF, 0, 0, OKAY);
    pwm_const("pwm_duty20", 1'b1);

    // Lowering PERIOD mid-period
    axi_write(14'h0000, 32'h0, 4'hF, 0, 0, OKAY);
    axi_write(14'h0004, 32'd99, 4'hF, 0, 0, OKAY);
    axi_write(14'h0008, 32'd5, 4'hF, 0, 0, OKAY);
    axi_write(14'h0000, 32'h1, 4'hF, 0, 0, OKAY);
    wait_rise("rise0", r0);
    repeat (45) @(posedge clk);
    #1;
    axi_write(14'h0004, 32'd9, 4'hF, 0, 0, OKAY);
    wait_rise("rise1", r1);
    wait_rise("rise2", r2);
`ifdef AXIL_PWM_SHADOW_EN
    check_eq("period_len_shadow", 64'(r1 - r0), 64'd100);
`else
    check_eq("period_len_forced_wrap", 64'((r1 - r0) >= 45 && (r1 - r0) <= 70), 64'd1);
`endif
    check_eq("period_len_new", 64'(r2 - r1), 64'd10);
    @(posedge clk); #1;
    axi_read(14'h0004, 32'd9, OKAY, 0);

    // Reset in the middle of a write: AW held, then reset
    awaddr = 14'h0004; awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("async_reset_out", {awready, bvalid, rvalid, pwm_out}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_after_abort", {awready, wready, arready, bvalid}, 4'b1110);
    @(posedge clk); #1;
    axi_read(14'h0004, 32'h0000_FFFF, OKAY, 0);
    axi_read(14'h0008, 32'h0000_8000, OKAY, 0);
    axi_read(14'h0000, 32'h0, OKAY, 0);

    repeat (2) @(posedge clk);
    check_eq("scoreboard_drained", 64'(bq.size() + rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
